// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Brief    : Shared types and constants for the instruction fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
package ifu_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          PC_STEP          = 4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : Fetch PC register with hold / +4 / aligned-redirect select and a
//            registered misaligned-redirect flag.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic            misaligned
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_misaligned;

  // Redirect beats the sequential step; the step wraps naturally at 2^XLEN.
  always_comb begin
    w_pc_nxt = r_pc;
    if (redirect_valid) begin
      w_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (advance) begin
      w_pc_nxt = r_pc + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  assign pc         = r_pc;
  assign misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_ctrl
// Brief    : Single-outstanding instruction fetch sequencer with stall and
//            redirect handling; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [XLEN-1:0]    pc_out,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               fetch_misaligned
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic               r_discard;
  logic               w_discard_nxt;
  logic               w_advance;
  logic               w_capture;
  logic [XLEN-1:0]    w_pc;

  logic               r_req_valid;
  logic               r_instr_valid;
  logic [INSTR_W-1:0] r_instr_out;
  logic [XLEN-1:0]    r_pc_out;

  fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst            (rst),
    .advance        (w_advance),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (w_pc),
    .misaligned     (fetch_misaligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_BOOT;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  // A redirect racing an in-flight request marks that response for dropping.
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_req_ready) begin
          w_state_nxt   = ST_WAIT;
          w_discard_nxt = redirect_valid;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          w_discard_nxt = 1'b0;
          w_state_nxt   = (r_discard || redirect_valid) ? ST_REQ : ST_OUT;
        end else if (redirect_valid) begin
          w_discard_nxt = 1'b1;
        end
      end
      ST_OUT: begin
        if (instr_ready || redirect_valid) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt   = ST_BOOT;
        w_discard_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_advance = (r_state == ST_OUT) && instr_ready && !redirect_valid;
    w_capture = (r_state == ST_WAIT) && imem_rsp_valid && !r_discard && !redirect_valid;
  end

  // Valids are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr_out   <= '0;
      r_pc_out      <= RESET_PC;
    end else begin
      r_req_valid   <= (w_state_nxt == ST_REQ);
      r_instr_valid <= (w_state_nxt == ST_OUT);
      if (w_capture) begin
        r_instr_out <= imem_rsp_data;
        r_pc_out    <= w_pc;
      end
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = w_pc;
  assign instr_valid    = r_instr_valid;
  assign instr_out      = r_instr_out;
  assign pc_out         = r_pc_out;

endmodule
`default_nettype wire

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Sequencing controller for the instruction fetch path: owns the program counter, issues one instruction-memory request at a time over a valid/ready handshake, and holds the returned instruction until downstream accepts it. It sits between the PC register/adder pair and the IFU, replacing free-running PC increment with stall- and redirect-aware fetch so the core tolerates multi-cycle memory latency and taken jumps/branches.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- XLEN, 64, PC/address width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address, word aligned
- imem_rsp_valid  in  1  response data valid (single-cycle pulse, no backpressure)
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  instr_out/pc_out hold a valid instruction
- instr_ready  in  1  downstream consumes instruction
- instr_out  out  32  fetched instruction
- pc_out  out  XLEN  address of instr_out
- redirect_valid  in  1  one-cycle request to change fetch PC
- redirect_pc  in  XLEN  new fetch PC
- fetch_misaligned  out  1  one-cycle pulse: redirect_pc[1:0] was nonzero

## Operation
- States: BOOT, REQ, WAIT, OUT.
- BOOT: entered on reset; one cycle, no request; next state REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> WAIT. Memory samples address only at handshake; address may change while unaccepted (redirect only).
- WAIT: one request outstanding, no new request. On imem_rsp_valid: if discard flag clear, capture data into instr_out, pc into pc_out, -> OUT; if set, drop data, clear flag, -> REQ.
- OUT: instr_valid=1, instr_out/pc_out stable. On instr_ready: pc <= pc+4, -> REQ.
- PC increment modulo 2^XLEN (all-ones-minus-3 wraps to 0).
- Redirect, highest priority, applied in any state: pc <= {redirect_pc[XLEN-1:2],2'b00}; fetch_misaligned pulses next cycle if redirect_pc[1:0]!=0.
  - BOOT: pc updated, proceed to REQ.
  - REQ (accepted or not same cycle): if accepted same cycle, go WAIT with discard set; else stay REQ with new address.
  - WAIT: set discard flag; rsp arriving same cycle as redirect is discarded.
  - OUT: held instruction dropped (instr_valid=0 next cycle) unless instr_ready same cycle, in which case consumption counts; either way pc = redirected value (no +4), -> REQ.
- Response outside WAIT is ignored.
- Reset mid-transaction: all state cleared; outstanding memory response after reset release is ignored (BOOT/REQ ignore rsp).

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr_out=32'h0, pc_out=RESET_PC, fetch_misaligned=0; state BOOT, discard=0, pc=RESET_PC.
- Memory response at least one cycle after request handshake.
- Request accepted cycle N, response cycle N+k (k>=1) -> instr_valid cycle N+k+1.
- Back-to-back with instr_ready tied high and k=1: one instruction per 3 cycles.
- Redirect in cycle N -> imem_req_addr shows redirected PC no later than cycle N+1 (N+k+1 if in WAIT, after dropped response).
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package ifu_pkg: fetch state enum (BOOT, REQ, WAIT, OUT), RESET_PC default, INSTR_W=32, PC_STEP=4.
- Sub-module fetch_pc_gen: pc register plus next-PC mux (hold / +4 / aligned redirect) and misalign detect; FSM and output registers stay in ifu_fetch_ctrl.

## Test plan
- Reset release, imem_req_ready=1, k=1, instr_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008; instr_out/pc_out pairs match memory, instr_valid every 3rd cycle.
- instr_ready low 5 cycles in OUT -> instr_out/pc_out stable, no new request; ready high -> next request 0x...+4.
- Redirect to 0x80001000 during WAIT with k=3 -> pending response dropped, no instr_valid, next request 0x80001000, its response delivered with pc_out=0x80001000.
- Redirect in OUT with instr_ready same cycle -> held instruction consumed once, next request at redirect_pc, not pc+4.
- Redirect to 0x80000102 -> request at 0x80000100, fetch_misaligned pulses one cycle.
- PC at 0xFFFF_FFFF_FFFF_FFFC consumed -> next request 0x0; rst asserted during WAIT -> outputs at reset values, stray response after release ignored, first request RESET_PC.
